// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared word-wide main-memory port.
// DC has priority; a streak counter bounds how long fetch can be starved.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            if_req,
  input  logic [31:0]     if_addr,
  output logic            if_ready,
  output logic [31:0]     if_rdata,
  input  logic            dc_req,
  input  logic            dc_we,
  input  logic [31:0]     dc_addr,
  input  logic [0:3][7:0] dc_wdata,
  output logic            dc_ready,
  output logic [0:3][7:0] dc_rdata,
  output logic [31:0]     mem_addr,
  output logic [0:3][7:0] mem_data_in,
  output logic            mem_write_en,
  input  logic [0:3][7:0] mem_data_out,
  output logic            busy,
  output logic            owner_dc
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      streak_q, streak_d;
  logic            owner_q, owner_d;
  logic            if_ready_q, if_ready_d;
  logic            dc_ready_q, dc_ready_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [0:3][7:0] dc_rdata_q, dc_rdata_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [0:3][7:0] mem_data_q, mem_data_d;
  logic            mem_we_q, mem_we_d;
  logic            dc_win;

  // Word addressing: the byte-offset bits never reach memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], dc_addr[1:0]};

  assign dc_win = dc_req && !(if_req && streak_q == LIM);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    owner_d    = owner_q;
    if_ready_d = 1'b0;
    dc_ready_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dc_rdata_d = dc_rdata_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = mem_we_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (if_req || dc_req) begin
          state_d = S_ACCESS;
          cnt_d   = LAT;
          owner_d = dc_win;
          if (dc_win) begin
            mem_addr_d = {dc_addr[31:2], 2'b00};
            mem_data_d = dc_wdata;
            mem_we_d   = dc_we;
            if (!if_req)
              streak_d = 4'd0;
            else if (streak_q >= LIM)
              streak_d = LIM;
            else
              streak_d = streak_q + 4'd1;
          end else begin
            mem_addr_d = {if_addr[31:2], 2'b00};
            mem_we_d   = 1'b0;
            streak_d   = 4'd0;
          end
        end
      end
      (state_q == S_ACCESS): begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = S_RESP;
          mem_we_d = 1'b0;
          if (owner_q) begin
            dc_rdata_d = mem_data_out;
            dc_ready_d = 1'b1;
          end else begin
            if_rdata_d = mem_data_out;
            if_ready_d = 1'b1;
          end
        end
      end
      (state_q == S_RESP): begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      streak_q   <= 4'd0;
      owner_q    <= 1'b0;
      if_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
      if_rdata_q <= '0;
      dc_rdata_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      owner_q    <= owner_d;
      if_ready_q <= if_ready_d;
      dc_ready_q <= dc_ready_d;
      if_rdata_q <= if_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign if_ready     = if_ready_q;
  assign dc_ready     = dc_ready_q;
  assign if_rdata     = if_rdata_q;
  assign dc_rdata     = dc_rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_data_q;
  assign mem_write_en = mem_we_q;
  assign busy         = (state_q != S_IDLE);
  assign owner_dc     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level reference
// predicts each grant and response; a monitor compares every cycle.
module tb_mem_port_arbiter;

  localparam int L  = 4;
  localparam int SL = 2;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            if_req, dc_req, dc_we;
  logic [31:0]     if_addr, dc_addr;
  logic [0:3][7:0] dc_wdata;
  logic            if_ready, dc_ready, mem_write_en, busy, owner_dc;
  logic [31:0]     if_rdata, mem_addr;
  logic [0:3][7:0] dc_rdata, mem_data_in, mem_data_out;

  logic            f_if_req;
  logic [31:0]     f_if_addr, f_if_rdata, f_mem_addr;
  logic            f_if_ready, f_dc_ready, f_mem_we, f_busy, f_owner;
  logic [0:3][7:0] f_dc_rdata, f_mem_data_in, f_mem_data_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] hashw(input int unsigned i);
    return ((i + 1) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req), .if_addr(if_addr),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
    .busy(busy), .owner_dc(owner_dc)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_fast (
    .clk(clk), .rst_b(rst_b),
    .if_req(f_if_req), .if_addr(f_if_addr),
    .if_ready(f_if_ready), .if_rdata(f_if_rdata),
    .dc_req(1'b0), .dc_we(1'b0), .dc_addr(32'h0),
    .dc_wdata(32'h0), .dc_ready(f_dc_ready), .dc_rdata(f_dc_rdata),
    .mem_addr(f_mem_addr), .mem_data_in(f_mem_data_in),
    .mem_write_en(f_mem_we), .mem_data_out(f_mem_data_out),
    .busy(f_busy), .owner_dc(f_owner)
  );

  // Physical memory seen by the DUT, and the reference's own copy.
  logic [31:0] pmem [0:255];
  logic [31:0] mmem [0:255];
  bit init_done = 1'b0;

  assign mem_data_out   = pmem[mem_addr[9:2]];
  assign f_mem_data_out = hashw(32'(f_mem_addr[9:2]));

  typedef struct {
    logic        owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          grant;
  } exp_t;

  exp_t exp_q[$];
  logic obs_log[$];
  int   free_at = 0;
  int   streak = 0;

  // Reference: one access at a time, L+2 edges from grant to next grant.
  always @(posedge clk) begin
    exp_t  n;
    logic  dcw;
    int    idx;
    if (!init_done) begin
      for (int i = 0; i < 256; i++) begin
        pmem[i] = hashw(i);
        mmem[i] = hashw(i);
      end
      pmem[64] = 32'hDEADBEEF;
      mmem[64] = 32'hDEADBEEF;
      init_done = 1'b1;
    end
    if (mem_write_en)
      pmem[mem_addr[9:2]] <= mem_data_in;
    cyc++;
    if (!rst_b) begin
      free_at = cyc + 1;
      streak  = 0;
      exp_q.delete();
    end else if (cyc >= free_at && (if_req || dc_req)) begin
      dcw     = dc_req && !(if_req && streak == SL);
      n.owner = dcw;
      n.we    = dcw && dc_we;
      n.addr  = dcw ? {dc_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
      n.wdata = dc_wdata;
      n.grant = cyc;
      idx     = int'(n.addr[9:2]);
      n.rdata = mmem[idx];
      if (n.we) mmem[idx] = dc_wdata;
      if (dcw) streak = if_req ? ((streak < SL) ? streak + 1 : SL) : 0;
      else     streak = 0;
      exp_q.push_back(n);
      free_at = cyc + L + 2;
    end
  end

  // Monitor: compares the DUT against the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (if_ready || dc_ready) obs_log.push_back(dc_ready);
      if (rst_b && exp_q.size() > 0 && cyc >= exp_q[0].grant &&
          cyc < exp_q[0].grant + L) begin
        e = exp_q[0];
        check("access",
              {busy, owner_dc, mem_write_en, if_ready, dc_ready, mem_addr},
              {1'b1, e.owner, e.we, 2'b00, e.addr});
        if (e.we) check("wdata", mem_data_in, e.wdata);
      end else if (rst_b && exp_q.size() > 0 &&
                   cyc == exp_q[0].grant + L) begin
        e = exp_q.pop_front();
        check("resp", {busy, mem_write_en, if_ready, dc_ready},
              {1'b1, 1'b0, !e.owner, e.owner});
        if (!e.we) check("rdata", e.owner ? dc_rdata : if_rdata, e.rdata);
      end else begin
        check("no_ready", {if_ready, dc_ready}, 2'b00);
      end
    end
  end

  task automatic if_xfer(input logic [31:0] a, output logic [31:0] rd,
                         output int lat, output int done);
    int t;
    if_addr = a;
    if_req  = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!if_ready && t < 200);
    check("if_timeout", if_ready, 1'b1);
    rd   = if_rdata;
    lat  = t;
    done = cyc;
    if_req = 1'b0;
  endtask

  task automatic dc_xfer(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, output int lat,
                         output int wen, output int done);
    int t;
    dc_we    = we;
    dc_addr  = a;
    dc_wdata = wd;
    dc_req   = 1'b1;
    t   = 0;
    wen = 0;
    do begin
      @(negedge clk);
      t++;
      if (mem_write_en) wen++;
    end while (!dc_ready && t < 200);
    check("dc_timeout", dc_ready, 1'b1);
    lat  = t;
    done = cyc;
    dc_req = 1'b0;
    dc_we  = 1'b0;
  endtask

  task automatic rand_if(input int n);
    logic [31:0] rd;
    int lat, dn;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if_xfer(32'($urandom_range(0, 1023)), rd, lat, dn);
    end
  endtask

  task automatic rand_dc(input int n);
    int lat, wen, dn;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      dc_xfer(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)),
              $urandom(), lat, wen, dn);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, cur;
    int lat, wen, d_if, d_dc, n, n0, last;
    rst_b = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    f_if_req = 1'b0; f_if_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {busy, owner_dc, if_ready, dc_ready, mem_write_en},
          5'b0);
    check("reset_mem", {mem_addr, mem_data_in}, 64'h0);
    check("reset_rdata", {if_rdata, dc_rdata}, 64'h0);
    rst_b  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Fetch only
    if_xfer(32'h100, rd, lat, d_if);
    check("fetch_lat", lat, L + 1);
    check("fetch_rdata", rd, 32'hDEADBEEF);
    repeat (2) @(negedge clk);

    // Contention: DC first, IF exactly L+2 later
    fork
      if_xfer(32'h100, rd, lat, d_if);
      dc_xfer(1'b0, 32'h200, 32'h0, lat, wen, d_dc);
    join
    check("contend_gap", d_if - d_dc, L + 2);
    repeat (2) @(negedge clk);

    // Starvation: both held high, expect DC,DC,IF,DC,DC,IF
    obs_log.delete();
    if_addr = 32'h10; dc_addr = 32'h20; dc_we = 1'b0;
    if_req = 1'b1; dc_req = 1'b1;
    n = 0;
    for (int t = 0; t < 200 && n < 6; t++) begin
      @(negedge clk);
      if (if_ready || dc_ready) n++;
      if (dc_ready) dc_addr = 32'($urandom_range(0, 1023));
      if (if_ready) if_addr = 32'($urandom_range(0, 1023));
    end
    if_req = 1'b0; dc_req = 1'b0;
    repeat (L + 3) @(negedge clk);
    check("starve_count", obs_log.size(), 6);
    if (obs_log.size() >= 6)
      check("starve_order",
            {obs_log[0], obs_log[1], obs_log[2],
             obs_log[3], obs_log[4], obs_log[5]}, 6'b110110);

    // DC write
    dc_xfer(1'b1, 32'h3C0, 32'h11223344, lat, wen, d_dc);
    check("write_wen_cycles", wen, L);
    check("write_lat", lat, L + 1);
    if_xfer(32'h3C0, rd, lat, d_if);
    check("write_readback", rd, 32'h11223344);
    @(negedge clk);

    // Reset during the second ACCESS cycle of a DC write
    dc_we = 1'b1; dc_addr = 32'h040; dc_wdata = $urandom(); dc_req = 1'b1;
    repeat (2) @(negedge clk);
    n0 = obs_log.size();
    rst_b = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    @(negedge clk);
    check("rst_mid", {mem_write_en, busy, if_ready, dc_ready}, 4'b0);
    rst_b = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_no_ready", obs_log.size(), n0);
    if_xfer(32'h080, rd, lat, d_if);
    check("rst_fetch_lat", lat, L + 1);
    check("rst_fetch_rdata", rd, hashw(32));

    // Randomized mixed traffic
    fork
      rand_if(40);
      rand_dc(40);
    join
    repeat (L + 3) @(negedge clk);

    // MEM_LATENCY = 1, back-to-back fetches with req held high
    cur = $urandom();
    f_if_addr = cur;
    f_if_req  = 1'b1;
    n = 0;
    last = 0;
    for (int t = 0; t < 40 && n < 5; t++) begin
      @(negedge clk);
      if (f_if_ready) begin
        check("fast_addr", f_mem_addr, {cur[31:2], 2'b00});
        check("fast_rdata", f_if_rdata, hashw(32'(cur[9:2])));
        if (n > 0) check("fast_gap", cyc - last, 3);
        last = cyc;
        n++;
        cur = $urandom();
        f_if_addr = cur;
      end
    end
    f_if_req = 1'b0;
    check("fast_count", n, 5);
    check("fast_no_dc", f_dc_ready, 1'b0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
